// File: rtl/strobe_divn_pkg.sv
// Shared types and parameter limits for the strobe_divn divider slice.
// Channel state is kept at the maximum width; bits above WIDTH stay zero and synthesis prunes them.
package strobe_divn_pkg;

   localparam int unsigned MIN_NUM_CH = 1;
   localparam int unsigned MAX_NUM_CH = 16;
   localparam int unsigned MIN_WIDTH  = 2;
   localparam int unsigned MAX_WIDTH  = 32;

   typedef logic [MAX_WIDTH-1:0] cnt_t;

   typedef struct packed {
      cnt_t div;   // active divisor
      cnt_t cnt;   // position within the current period
      cnt_t pdiv;  // divisor waiting to be applied
      logic pend;
   } ch_state_t;

   function automatic int unsigned ch_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/strobe_divn_if.sv
// Divisor write handshake between a configuration master and strobe_divn.
interface strobe_divn_if
   import strobe_divn_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned WIDTH  = 16
);

   localparam int unsigned CH_W = ch_idx_width(NUM_CH);

   logic            i_wr_valid;
   logic [CH_W-1:0] i_wr_ch;
   logic [WIDTH-1:0] i_wr_div;
   logic            o_wr_ready;

   modport master (
      output i_wr_valid,
      output i_wr_ch,
      output i_wr_div,
      input  o_wr_ready
   );

   modport slave (
      input  i_wr_valid,
      input  i_wr_ch,
      input  i_wr_div,
      output o_wr_ready
   );

endinterface

// File: rtl/strobe_divn_ch.sv
// One strobe channel: period counter, registered strobe and a single-entry pending divisor.
// STROBE_DIVN_COUNT_OUT_EN exposes the counter on o_cnt.
module strobe_divn_ch
   import strobe_divn_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr_take,
   input  logic [WIDTH-1:0] i_wr_div,
   output logic             o_strobe,
   output logic             o_pend
`ifdef STROBE_DIVN_COUNT_OUT_EN
   ,
   output logic [WIDTH-1:0] o_cnt
`endif
);

   localparam ch_state_t RESET_STATE = '{
      div:  cnt_t'(DEFAULT_DIV),
      cnt:  '0,
      pdiv: '0,
      pend: 1'b0
   };

   ch_state_t state_q, state_d;
   logic      strobe_q, strobe_d;
   logic      wrap;
   logic      apply;

   always_comb begin
      state_d  = state_q;
      strobe_d = 1'b0;
      wrap     = i_en && !i_sync && (state_q.cnt >= state_q.div - cnt_t'(1));
      apply    = state_q.pend && (i_sync || !i_en || wrap);

      if (i_sync) begin
         state_d.cnt = '0;
      end else if (i_en) begin
         if (wrap) begin
            state_d.cnt = '0;
            strobe_d    = 1'b1;
         end else begin
            state_d.cnt = state_q.cnt + cnt_t'(1);
         end
      end

      // Apply before capturing a new write so a same-cycle write becomes the next pending value.
      if (apply) begin
         state_d.div  = state_q.pdiv;
         state_d.cnt  = '0;
         state_d.pend = 1'b0;
      end

      if (i_wr_take) begin
         state_d.pdiv = cnt_t'(i_wr_div);
         state_d.pend = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= RESET_STATE;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
      end
   end

   assign o_strobe = strobe_q;
   assign o_pend   = state_q.pend;

`ifdef STROBE_DIVN_COUNT_OUT_EN
   assign o_cnt = state_q.cnt[WIDTH-1:0];
`endif

endmodule

// File: rtl/strobe_divn.sv
// Multi-channel programmable strobe divider: write decode, sticky zero-divisor error, channel array.
// Define STROBE_DIVN_COUNT_OUT_EN to add o_count exposing every channel counter.
module strobe_divn
   import strobe_divn_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [NUM_CH-1:0] i_en,
   input  logic              i_sync,
   strobe_divn_if.slave      wr_if,
   input  logic              i_err_clr,
   output logic [NUM_CH-1:0] o_strobe,
   output logic              o_err
`ifdef STROBE_DIVN_COUNT_OUT_EN
   ,
   output logic [NUM_CH*WIDTH-1:0] o_count
`endif
);

   localparam int unsigned CH_W = ch_idx_width(NUM_CH);

   if (NUM_CH < MIN_NUM_CH || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
      $error("strobe_divn: NUM_CH=%0d out of range", NUM_CH);
   end
   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("strobe_divn: WIDTH=%0d out of range", WIDTH);
   end
   if (DEFAULT_DIV == 0 || 64'(DEFAULT_DIV) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_default_div
      $error("strobe_divn: DEFAULT_DIV=%0d out of range", DEFAULT_DIV);
   end

   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] take;
   logic              wr_ready;
   logic              accept;
   logic              zero_wr;
   logic              err_q, err_d;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_hit
      assign hit[c] = (wr_if.i_wr_ch == CH_W'(c));
   end

   // Out-of-range channel indices match no hit bit, so they are always ready and silently dropped.
   always_comb begin
      wr_ready = !(|(hit & pend));
      accept   = wr_if.i_wr_valid && wr_ready;
      zero_wr  = accept && (wr_if.i_wr_div == '0);
      take     = hit & {NUM_CH{accept && !zero_wr}};

      err_d = err_q;
      if (i_err_clr) begin
         err_d = 1'b0;
      end
      if (zero_wr) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign wr_if.o_wr_ready = wr_ready;
   assign o_err            = err_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      strobe_divn_ch #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_en      (i_en[c]),
         .i_sync    (i_sync),
         .i_wr_take (take[c]),
         .i_wr_div  (wr_if.i_wr_div),
         .o_strobe  (o_strobe[c]),
         .o_pend    (pend[c])
`ifdef STROBE_DIVN_COUNT_OUT_EN
         ,
         .o_cnt     (o_count[c*WIDTH +: WIDTH])
`endif
      );
   end

endmodule

// File: tb/tb_strobe_divn.sv
// Self-checking bench for strobe_divn: vector table with per-cycle scoreboard plus a reset corner case.
module tb_strobe_divn;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned WIDTH  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              err_clr;
   logic [NUM_CH-1:0] strobe;
   logic              err;
`ifdef STROBE_DIVN_COUNT_OUT_EN
   logic [NUM_CH*WIDTH-1:0] count;
`endif

   strobe_divn_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) wr_if ();

   strobe_divn #(
      .NUM_CH      (NUM_CH),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (2)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_en      (en),
      .i_sync    (sync),
      .wr_if     (wr_if),
      .i_err_clr (err_clr),
      .o_strobe  (strobe),
      .o_err     (err)
`ifdef STROBE_DIVN_COUNT_OUT_EN
      ,
      .o_count   (count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  en;
      logic        sync;
      logic        wv;
      logic [1:0]  ch;
      logic [15:0] div;
      logic        clr;
      logic        rdy;
      logic [3:0]  stb;
      logic        err;
   } vec_t;

   typedef struct {
      logic [3:0] stb;
      logic       err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t v(input logic [3:0] en_i, input int sync_i, input int wv_i,
                              input int ch_i, input int div_i, input int clr_i,
                              input int rdy_i, input logic [3:0] stb_i, input int err_i);
      vec_t r;
      r.en   = en_i;
      r.sync = (sync_i != 0);
      r.wv   = (wv_i != 0);
      r.ch   = 2'(ch_i);
      r.div  = 16'(div_i);
      r.clr  = (clr_i != 0);
      r.rdy  = (rdy_i != 0);
      r.stb  = stb_i;
      r.err  = (err_i != 0);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t x, input int idx);
      exp_t e;
      @(negedge clk);
      en               = x.en;
      sync             = x.sync;
      err_clr          = x.clr;
      wr_if.i_wr_valid = x.wv;
      wr_if.i_wr_ch    = x.ch;
      wr_if.i_wr_div   = x.div;
      #1;
      check($sformatf("ready[%0d]", idx), 32'(wr_if.o_wr_ready), 32'(x.rdy));
      e.stb = x.stb;
      e.err = x.err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard[%0d]: got empty expected entry", idx);
      end else begin
         e = sb.pop_front();
         check($sformatf("strobe[%0d]", idx), 32'(strobe), 32'(e.stb));
         check($sformatf("err[%0d]", idx), 32'(err), 32'(e.err));
      end
   endtask

   initial begin
      // Default divisor 2 on ch0: strobes on every second cycle
      for (int unsigned i = 0; i < 3; i++) begin
         vecs.push_back(v(4'b0001, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
         vecs.push_back(v(4'b0001, 0, 0, 0, 0, 0, 1, 4'b0001, 0));
      end
      // Divisor 5 written to ch1 on its last count; old period completes first
      vecs.push_back(v(4'b0011, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0011, 0, 1, 1, 5, 0, 1, 4'b0011, 0));
      vecs.push_back(v(4'b0011, 0, 1, 1, 7, 0, 0, 4'b0000, 0));
      vecs.push_back(v(4'b0011, 0, 0, 1, 0, 0, 0, 4'b0011, 0));
      vecs.push_back(v(4'b0011, 0, 0, 1, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0011, 0, 0, 1, 0, 0, 1, 4'b0001, 0));
      vecs.push_back(v(4'b0011, 0, 0, 1, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0011, 0, 0, 1, 0, 0, 1, 4'b0001, 0));
      vecs.push_back(v(4'b0011, 0, 0, 1, 0, 0, 1, 4'b0010, 0));
      // Zero divisor sets sticky error; set beats a concurrent clear
      vecs.push_back(v(4'b0000, 0, 1, 2, 0, 0, 1, 4'b0000, 1));
      vecs.push_back(v(4'b0000, 0, 0, 2, 0, 0, 1, 4'b0000, 1));
      vecs.push_back(v(4'b0000, 0, 0, 2, 0, 1, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0000, 0, 0, 2, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0000, 0, 1, 2, 0, 1, 1, 4'b0000, 1));
      vecs.push_back(v(4'b0000, 0, 0, 2, 0, 1, 1, 4'b0000, 0));
      // Divisors 3/4/7 applied while disabled, then sync mid-period (ch1 would wrap)
      vecs.push_back(v(4'b0000, 0, 1, 0, 3, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0000, 0, 1, 1, 4, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0000, 0, 1, 2, 7, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0001, 0));
      vecs.push_back(v(4'b0111, 1, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0001, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0010, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0001, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0100, 0));
      vecs.push_back(v(4'b0111, 0, 0, 0, 0, 0, 1, 4'b0010, 0));
      // Divisor 1 on ch3: constant strobe, dropped for one disabled cycle
      vecs.push_back(v(4'b1000, 0, 1, 3, 1, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b1000, 0, 0, 3, 0, 0, 0, 4'b1000, 0));
      vecs.push_back(v(4'b1000, 0, 0, 0, 0, 0, 1, 4'b1000, 0));
      vecs.push_back(v(4'b1000, 0, 0, 0, 0, 0, 1, 4'b1000, 0));
      vecs.push_back(v(4'b1000, 0, 0, 0, 0, 0, 1, 4'b1000, 0));
      vecs.push_back(v(4'b0000, 0, 0, 0, 0, 0, 1, 4'b0000, 0));
      vecs.push_back(v(4'b1000, 0, 0, 0, 0, 0, 1, 4'b1000, 0));
      // Leave ch1 pending and the error set ahead of the reset corner case
      vecs.push_back(v(4'b1010, 0, 1, 1, 6, 0, 1, 4'b1000, 0));
      vecs.push_back(v(4'b1010, 0, 1, 2, 0, 0, 1, 4'b1000, 1));

      rst_n            = 1'b0;
      en               = '0;
      sync             = 1'b0;
      err_clr          = 1'b0;
      wr_if.i_wr_valid = 1'b0;
      wr_if.i_wr_ch    = '0;
      wr_if.i_wr_div   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_strobe", 32'(strobe), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      check("reset_ready", 32'(wr_if.o_wr_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run(vecs[i], i);
      end

      // Asynchronous reset mid-period with ch1 pending and ch3 strobing
      @(negedge clk);
      wr_if.i_wr_valid = 1'b0;
      wr_if.i_wr_ch    = 2'd1;
      #1;
      check("pre_rst_ready", 32'(wr_if.o_wr_ready), 32'h0);
      check("pre_rst_strobe", 32'(strobe), 32'h8);
      rst_n = 1'b0;
      en    = '0;
      #1;
      check("async_rst_strobe", 32'(strobe), 32'h0);
      check("async_rst_err", 32'(err), 32'h0);
      check("async_rst_ready", 32'(wr_if.o_wr_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      run(v(4'b1010, 0, 0, 1, 0, 0, 1, 4'b0000, 0), 100);
      run(v(4'b1010, 0, 0, 1, 0, 0, 1, 4'b1010, 0), 101);
      run(v(4'b1010, 0, 0, 1, 0, 0, 1, 4'b0000, 0), 102);
      run(v(4'b1010, 0, 0, 1, 0, 0, 1, 4'b1010, 0), 103);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/strobe_divn.md
STROBE_DIVN -- requirements
Module: strobe_divn

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent strobe channels, SHALL be 1..16.
REQ-002 Parameter WIDTH, default 16: divisor/counter width in bits, SHALL be 2..32.
REQ-003 Parameter DEFAULT_DIV, default 2: divisor loaded at reset, SHALL be 1..2^WIDTH-1; violation SHALL raise an elaboration $error.
REQ-004 i_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_en  in  NUM_CH  per-channel count enable.
REQ-007 i_sync  in  1  phase-align pulse, restarts all channels.
REQ-008 i_wr_valid  in  1  divisor write request.
REQ-009 i_wr_ch  in  $clog2(NUM_CH) (min 1)  target channel of write.
REQ-010 i_wr_div  in  WIDTH  new divisor (period in cycles).
REQ-011 o_wr_ready  out  1  write accept; high when target channel has no pending divisor.
REQ-012 i_err_clr  in  1  clears o_err.
REQ-013 o_strobe  out  NUM_CH  registered one-cycle strobe per channel.
REQ-014 o_err  out  1  sticky flag: zero divisor written.

Function
REQ-015 Each channel SHALL hold an active divisor D, counter cnt (WIDTH bits), pending divisor P with flag pend.
REQ-016 Channel enabled, no sync: cnt==D-1 -> cnt<=0, o_strobe<=1; else cnt<=cnt+1, o_strobe<=0.
REQ-017 Channel disabled: cnt SHALL hold, o_strobe<=0.
REQ-018 From cnt=0 with enable continuously high, first strobe SHALL appear D cycles later, then every D cycles; D=1 SHALL give o_strobe constantly high.
REQ-019 Write accepted when i_wr_valid && o_wr_ready; o_wr_ready SHALL be combinational on !pend[i_wr_ch].
REQ-020 Accepted nonzero write SHALL set P=i_wr_div, pend=1 next cycle; i_wr_ch >= NUM_CH SHALL be accepted and discarded.
REQ-021 Accepted write with i_wr_div==0 SHALL be discarded and set o_err; o_err set SHALL win over simultaneous i_err_clr.
REQ-022 pend SHALL be applied (D<=P, cnt<=0, pend<=0) on the cycle the channel wraps, on any cycle the channel is disabled, or on i_sync; never mid-period otherwise.
REQ-023 A write accepted in the same cycle as an application for that channel SHALL become the new P after the application (no loss).
REQ-024 i_sync SHALL, next cycle, set cnt=0 and o_strobe=0 on all channels regardless of i_en; sync SHALL take priority over wrap.
REQ-025 Counter SHALL never exceed D-1; no wrap beyond 2^WIDTH-1.

Reset
REQ-026 i_reset_n low SHALL immediately force cnt=0, D=DEFAULT_DIV, pend=0, o_strobe=0, o_err=0.
REQ-027 Reset mid-period or with write pending SHALL discard all state; first strobe after release SHALL follow REQ-018 with D=DEFAULT_DIV.

Configuration
REQ-028 Macro STROBE_DIVN_COUNT_OUT_EN defined: add output o_count (NUM_CH*WIDTH, channel c at bits [c*WIDTH +: WIDTH]) exposing cnt; undefined: port absent, behaviour otherwise identical.

Structure
REQ-029 Package strobe_divn_pkg SHALL hold the per-channel state struct typedef and MIN/MAX parameter constants.
REQ-030 Per-channel counter/pending logic SHALL be sub-module strobe_divn_ch, instantiated NUM_CH times; write decode and o_err in top.

Verification
REQ-031 Reset, i_en=1 on ch0, DEFAULT_DIV=2 -> o_strobe[0] pulses cycles 2,4,6; other channels 0.
REQ-032 Write ch1 div=5 mid-period (cnt=1 of D=2) -> D=2 finishes, then period 5; second write before apply -> o_wr_ready=0.
REQ-033 Write div=0 -> o_err=1 held; i_err_clr -> 0; zero write concurrent with clr -> o_err=1.
REQ-034 Channels D=3,4,7 running, i_sync pulse -> all o_strobe 0 next cycle, first strobes 3,4,7 cycles after sync.
REQ-035 Write div=1 -> o_strobe constantly 1 after apply; i_en=0 -> 0 next cycle, cnt held.
REQ-036 Assert i_reset_n low mid-period with pend=1 -> outputs 0 immediately; after release period = DEFAULT_DIV.
